// File: rtl/float_mul_pkg.sv
// float_mul_pkg: shared constants and FSM encoding for the shared float multiplier scheduler.
package float_mul_pkg;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, GAP = 2'd2} state_t;
endpackage

// File: rtl/float_mul_sched_rr_pick.sv
// rr_pick: combinational round-robin select, first set request at or after ptr (mod NREQ).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);
  localparam logic [IDW:0] N = (IDW+1)'(NREQ);
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic [IDW:0]      w_sum;
  // w_rot[i] is req[(ptr+i) mod NREQ], so the lowest set bit is the winner
  assign w_dbl = {req, req};
  assign w_rot = NREQ'(w_dbl >> ptr);
  always_comb begin
    w_off = '0;
    for (int i = NREQ-1; i >= 0; i--) w_off = w_rot[i] ? IDW'(i) : w_off;
  end
  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign valid = |w_rot;
  assign idx = (w_sum >= N) ? IDW'(w_sum - N) : IDW'(w_sum);
endmodule

// File: rtl/float_mul_sched.sv
// float_mul_sched: shares one Start/Done float multiplier among NREQ requesters,
// round-robin grant, tagged one-cycle ack, watchdog abort returning qNaN.
module float_mul_sched
  import float_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [NREQ-1:0]      Req_Sig,
  input  logic [NREQ*32-1:0]   Req_A,
  input  logic [NREQ*32-1:0]   Req_B,
  output logic [NREQ-1:0]      Ack_Sig,
  output logic [31:0]          Result_Out,
  output logic [IDW-1:0]       Result_Id,
  output logic                 Err_Sig,
  output logic                 Busy,
  output logic [31:0]          Mul_A,
  output logic [31:0]          Mul_B,
  output logic                 Mul_Start,
  input  logic                 Mul_Done,
  input  logic [31:0]          Mul_Result
);
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  state_t            r_state, w_nxt;
  logic [IDW-1:0]    r_ptr, r_cur, w_idx;
  logic [WDW-1:0]    r_wdog;
  logic [NREQ-1:0]   r_ack;
  logic [31:0]       r_res, r_mul_a, r_mul_b;
  logic [IDW-1:0]    r_rid;
  logic              r_err, r_start, w_valid, w_tmo, w_fin;
  logic [31:0]       w_a [NREQ];
  logic [31:0]       w_b [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a[g] = Req_A[32*g +: 32];
    assign w_b[g] = Req_B[32*g +: 32];
  end
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(Req_Sig), .ptr(r_ptr), .valid(w_valid), .idx(w_idx)
  );
  assign w_tmo = (r_wdog == WDW'(TIMEOUT-1));
  assign w_fin = Mul_Done || w_tmo;
  always_comb begin
    w_nxt = IDLE;
    w_nxt = (r_state == IDLE) ? (w_valid ? WAIT : IDLE) :
            (r_state == WAIT) ? (w_fin ? GAP : WAIT) : IDLE;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) r_state <= IDLE;
    else r_state <= w_nxt;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      r_ptr   <= '0;
      r_cur   <= '0;
      r_wdog  <= '0;
      r_ack   <= '0;
      r_res   <= '0;
      r_rid   <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (r_state == IDLE) begin
      if (w_valid) begin
        r_mul_a <= w_a[w_idx];
        r_mul_b <= w_b[w_idx];
        r_start <= 1'b1;
        r_cur   <= w_idx;
        r_ptr   <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
        r_wdog  <= '0;
      end
    end else if (r_state == WAIT) begin
      if (w_fin) begin
        // a real Done wins over a simultaneous watchdog expiry
        r_start <= 1'b0;
        r_res   <= Mul_Done ? Mul_Result : FP_QNAN;
        r_rid   <= r_cur;
        r_ack   <= NREQ'(1) << r_cur;
        r_err   <= !Mul_Done;
      end else r_wdog <= r_wdog + 1'b1;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
    end
  assign Ack_Sig    = r_ack;
  assign Result_Out = r_res;
  assign Result_Id  = r_rid;
  assign Err_Sig    = r_err;
  assign Busy       = (r_state == WAIT) || (r_state == GAP);
  assign Mul_A      = r_mul_a;
  assign Mul_B      = r_mul_b;
  assign Mul_Start  = r_start;
endmodule

// File: doc/float_mul_sched.md
Name: float_mul_sched

Overview:
- Shares one float_multi_module (32-bit IEEE-754 single multiplier, Start_Sig/Done_Sig handshake) among NREQ independent requesters.
- Arbitrates round-robin, latches the winner's operands, sequences Start/Done, returns the product with a one-cycle acknowledge tagged by requester index.
- Includes a watchdog that aborts a hung multiply.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; equals clog2(NREQ).
- TIMEOUT, 64, maximum WAIT cycles before abort (>=2).

Ports:
- CLK  in  1  clock.
- RSTn  in  1  reset, asynchronous, active-low.
- Req_Sig  in  NREQ  per-requester request level; held until matching Ack_Sig bit.
- Req_A  in  NREQ*32  operand A, requester k at bits [32k+31:32k]; stable while Req_Sig[k] is high.
- Req_B  in  NREQ*32  operand B, same packing.
- Ack_Sig  out  NREQ  one-hot, one-cycle completion pulse.
- Result_Out  out  32  product for the acked requester; valid while Ack_Sig != 0, held afterwards.
- Result_Id  out  IDW  index of the acked requester.
- Err_Sig  out  1  one-cycle pulse, coincident with Ack_Sig, on timeout abort.
- Busy  out  1  high in WAIT and GAP.
- Mul_A, Mul_B  out  32 each  operands to the multiplier.
- Mul_Start  out  1  to multiplier Start_Sig.
- Mul_Done  in  1  from multiplier Done_Sig[0].
- Mul_Result  in  32  from multiplier Result.

Behaviour:
- Reset values: Ack_Sig=0, Result_Out=0, Result_Id=0, Err_Sig=0, Mul_A=0, Mul_B=0, Mul_Start=0. Internal state: state=IDLE, ptr=0, wdog=0.
- Busy is decoded from state (WAIT or GAP); it is 0 in reset.
- FSM has three states: IDLE, WAIT, GAP.
- IDLE, any Req_Sig bit high:
  - Winner = first set bit scanning ptr, ptr+1, ... mod NREQ.
  - On that edge: Mul_A/Mul_B <= winner's operands; Mul_Start <= 1; cur_id <= winner; ptr <= (winner+1) mod NREQ; wdog <= 0; go WAIT.
  - Mul_Start therefore rises one cycle after the request is sampled.
- IDLE, no request: stay; all outputs hold.
- WAIT, Mul_Done=1: Mul_Start <= 0; Result_Out <= Mul_Result; Result_Id <= cur_id; Ack_Sig <= one-hot(cur_id); go GAP.
- WAIT, Mul_Done=0, wdog==TIMEOUT-1: Mul_Start <= 0; Result_Out <= 32'h7FC00000 (qNaN); Result_Id <= cur_id; Ack_Sig <= one-hot(cur_id); Err_Sig <= 1; go GAP.
- WAIT, otherwise: wdog <= wdog+1; Mul_Start stays 1.
- GAP (exactly one cycle): Ack_Sig and Err_Sig are visible; on exit they clear to 0; go IDLE.
  - Mul_Start is low in GAP, which gives the multiplier its required Start-low cycle.
  - A requester registering on Ack drops Req_Sig on the GAP->IDLE edge, so it is never regranted on a stale request.
- Mul_Done received outside WAIT is ignored.
- Mul_A/Mul_B are held from grant until the next grant. Request operands may change after ack.
- Fairness: with all NREQ requesting continuously, the grant order is 0,1,..,NREQ-1,0,...
- Latency with a multiplier latency of L cycles (Start high to Done high): request sampled -> Ack_Sig high after L+2 edges. Back-to-back throughput is one result per L+3 cycles.
- A request that deasserts before being granted is simply dropped; no ack is issued.
- Reset mid-operation: everything returns to reset values immediately and the in-flight multiply is abandoned (Mul_Start=0).
- No arithmetic is performed in this block. Sign, exponent and mantissa handling belong to the multiplier.

Decomposition:
- Shared package float_mul_pkg holds:
  - FP_QNAN = 32'h7FC00000.
  - State encodings: IDLE=2'd0, WAIT=2'd1, GAP=2'd2.
- Sub-module rr_pick: combinational round-robin priority select.
  - Inputs: req[NREQ], ptr[IDW].
  - Outputs: valid, idx[IDW].
  - Reusable by other shared float units.

Test Plan:
The bench uses a behavioural multiplier model with programmable latency L (default 5) and a hang mode.
- Single requester 0: A=32'h40200000 (2.5), B=32'h40A00000 (5) -> Ack_Sig=4'b0001 after L+2 cycles, Result_Out=32'h41480000, Result_Id=0, Err_Sig=0.
- Requesters 0..3 all request simultaneously:
  - Operands 2*2, 1024*256, 0.125*0.125, 2.5*5.
  - Acks in order 0,1,2,3.
  - Results 32'h40800000, 32'h48800000, 32'h3C800000, 32'h41480000.
  - Spacing between acks is L+3 cycles.
- Round-robin wrap: ptr=2 after serving 1; requests 0 and 3 pending -> 3 granted before 0.
- Hang mode (model never raises Done): Mul_Start drops after TIMEOUT cycles in WAIT; Ack plus Err_Sig pulse; Result_Out=32'h7FC00000. The next request completes normally.
- RSTn pulsed low in the middle of WAIT -> Mul_Start, Ack_Sig and Busy are 0 immediately. After release, a new request from requester 2 is served first (ptr=0, only requester 2 requesting).
- Mul_Done spuriously high while IDLE -> no Ack, no state change.
